// File: rtl/dram_pkg.sv
// dram_pkg: shared types and constants for the FSB DRAM sequencer.
// Holds the state enum, the timer width and the default timing values.
package dram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAS,
    CAS,
    HOLD,
    PRE,
    REF_CAS,
    REF_RAS
  } state_t;

  localparam int CW = 3;

  localparam int TRP_D  = 2;
  localparam int TRCD_D = 1;
  localparam int TCAS_D = 2;
  localparam int TREF_D = 3;

endpackage

// File: rtl/dram_tmr.sv
// dram_tmr: loadable down-counter that times every sequencer state.
// Ports: clk, rst, load, val (reload value) in; zero (count is 0) out.
module dram_tmr
  import dram_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] val,
  output logic          zero
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dram_sched.sv
// dram_sched: DRAM cycle sequencer and FSB/refresh arbiter (CBR refresh).
// In: FCLK, RES, BACT, RAMCS, nWE, nLDS, nUDS, RefReq, RefUrg.
// Out: RefAck, RASEL, nRAS, nCAS, nRAMLWE, nRAMUWE, nOE, RAMReady.
// Define DRAM_REFQ_EN to queue up to 3 deferred refreshes.
module dram_sched
  import dram_pkg::*;
#(
  parameter int TRP  = TRP_D,
  parameter int TRCD = TRCD_D,
  parameter int TCAS = TCAS_D,
  parameter int TREF = TREF_D
) (
  input  logic FCLK,
  input  logic RES,
  input  logic BACT,
  input  logic RAMCS,
  input  logic nWE,
  input  logic nLDS,
  input  logic nUDS,
  input  logic RefReq,
  input  logic RefUrg,
  output logic RefAck,
  output logic RASEL,
  output logic nRAS,
  output logic nCAS,
  output logic nRAMLWE,
  output logic nRAMUWE,
  output logic nOE,
  output logic RAMReady
);

`ifdef DRAM_REFQ_EN
  localparam int PW = 2;
`else
  localparam int PW = 1;
`endif

  state_t        state;
  state_t        nxt;
  logic          tz;
  logic          tld;
  logic [CW-1:0] tval;
  logic          ref_q;
  logic          ug_q;
  logic          urg_f;
  logic [PW-1:0] pend;
  logic [PW-1:0] pinc;
  logic [PW-1:0] pnxt;
  logic          req;
  logic          new_ref;
  logic          new_urg;
  logic          force_u;
  logic          dem;
  logic          urg;
  logic          more;
  logic          acc;

  // Refresh requests are counted on their rising edge so a level
  // held until RefAck is seen only once.
  assign req     = BACT & RAMCS & ~RAMReady;
  assign new_ref = RefReq & ~ref_q;
  assign new_urg = RefUrg & ~ug_q;
  assign dem     = new_ref | (pend != '0);

`ifdef DRAM_REFQ_EN
  logic ref_run;
  // Queue full: a further request makes the refresh urgent.
  assign force_u = new_ref & (&pend);
  // Drain the queue with back-to-back CBR cycles.
  assign more    = ref_run & dem;
`else
  assign force_u = 1'b0;
  assign more    = 1'b0;
`endif

  assign urg  = urg_f | new_urg | force_u;
  assign pinc = (new_ref && !(&pend)) ? pend + 1'b1 : pend;
  assign pnxt = (acc && pinc != '0) ? pinc - 1'b1 : pinc;

  always_comb begin
    nxt = state;
    acc = 1'b0;
    unique case (state)
      IDLE: begin
        if (urg || (dem && !req)) begin
          nxt = REF_CAS;
          acc = 1'b1;
        end else if (req) begin
          nxt = RAS;
        end
      end
      RAS:     if (tz) nxt = CAS;
      CAS:     if (tz) nxt = BACT ? HOLD : PRE;
      HOLD:    if (!BACT) nxt = PRE;
      PRE: begin
        // An overdue refresh is taken straight from precharge.
        if (tz) begin
          if (urg || more) begin
            nxt = REF_CAS;
            acc = 1'b1;
          end else begin
            nxt = IDLE;
          end
        end
      end
      REF_CAS: if (tz) nxt = REF_RAS;
      REF_RAS: if (tz) nxt = PRE;
      default: nxt = IDLE;
    endcase
  end

  assign tld = (nxt != state);

  always_comb begin
    unique case (nxt)
      RAS:     tval = CW'(TRCD - 1);
      CAS:     tval = CW'(TCAS - 1);
      PRE:     tval = CW'(TRP - 1);
      REF_RAS: tval = CW'(TREF - 1);
      default: tval = '0;
    endcase
  end

  dram_tmr u_tmr (
    .clk  (FCLK),
    .rst  (RES),
    .load (tld),
    .val  (tval),
    .zero (tz)
  );

  always_ff @(posedge FCLK or posedge RES) begin
    if (RES) begin
      state    <= IDLE;
      pend     <= '0;
      ref_q    <= 1'b0;
      ug_q     <= 1'b0;
      urg_f    <= 1'b0;
      RefAck   <= 1'b0;
      RASEL    <= 1'b1;
      nRAS     <= 1'b1;
      nCAS     <= 1'b1;
      nRAMLWE  <= 1'b1;
      nRAMUWE  <= 1'b1;
      nOE      <= 1'b1;
      RAMReady <= 1'b0;
`ifdef DRAM_REFQ_EN
      ref_run  <= 1'b0;
`endif
    end else begin
      state  <= nxt;
      pend   <= pnxt;
      ref_q  <= RefReq;
      ug_q   <= RefUrg;
      urg_f  <= acc ? 1'b0 : urg;
      RefAck <= acc;
`ifdef DRAM_REFQ_EN
      if (acc) ref_run <= 1'b1;
      else if (nxt == RAS) ref_run <= 1'b0;
`endif
      // CBR: nCAS leads nRAS by one cycle.
      if (acc) nCAS <= 1'b0;
      unique case (state)
        IDLE: begin
          if (nxt == RAS) begin
            nRAS  <= 1'b0;
            RASEL <= 1'b1;
          end
        end
        RAS: begin
          if (nxt == CAS) begin
            RASEL <= 1'b0;
            nCAS  <= 1'b0;
            if (nWE) begin
              nOE <= 1'b0;
            end else begin
              nRAMLWE <= nLDS;
              nRAMUWE <= nUDS;
            end
          end
        end
        CAS: if (nxt == HOLD) RAMReady <= 1'b1;
        REF_CAS: if (nxt == REF_RAS) nRAS <= 1'b0;
        default: ;
      endcase
      if (nxt == PRE && state != PRE) begin
        nRAS     <= 1'b1;
        nCAS     <= 1'b1;
        nOE      <= 1'b1;
        nRAMLWE  <= 1'b1;
        nRAMUWE  <= 1'b1;
        RASEL    <= 1'b1;
        RAMReady <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dram_sched.sv
// tb_dram_sched: directed self-checking bench for dram_sched.
// Output vector: {nRAS,nCAS,nOE,nRAMLWE,nRAMUWE,RASEL,RAMReady,RefAck}.
module tb_dram_sched;

  logic FCLK = 1'b0;
  logic RES, BACT, RAMCS, nWE, nLDS, nUDS, RefReq, RefUrg;
  logic RefAck, RASEL, nRAS, nCAS, nRAMLWE, nRAMUWE, nOE, RAMReady;
  int   n_chk = 0;
  int   n_fail = 0;
  int   acks;

`ifdef DRAM_REFQ_EN
  localparam int EXP_ACKS = 3;
`else
  localparam int EXP_ACKS = 1;
`endif

  localparam logic [7:0] IDL  = 8'b1111_1100;
  localparam logic [7:0] RASV = 8'b0111_1100;
  localparam logic [7:0] CRD  = 8'b0001_1000;
  localparam logic [7:0] HRD  = 8'b0001_1010;
  localparam logic [7:0] CWL  = 8'b0010_1000;
  localparam logic [7:0] HWL  = 8'b0010_1010;
  localparam logic [7:0] RCAS = 8'b1011_1101;
  localparam logic [7:0] RRAS = 8'b0011_1100;

  wire [7:0] obs = {nRAS, nCAS, nOE, nRAMLWE,
                    nRAMUWE, RASEL, RAMReady, RefAck};

  dram_sched dut (
    .FCLK     (FCLK),
    .RES      (RES),
    .BACT     (BACT),
    .RAMCS    (RAMCS),
    .nWE      (nWE),
    .nLDS     (nLDS),
    .nUDS     (nUDS),
    .RefReq   (RefReq),
    .RefUrg   (RefUrg),
    .RefAck   (RefAck),
    .RASEL    (RASEL),
    .nRAS     (nRAS),
    .nCAS     (nCAS),
    .nRAMLWE  (nRAMLWE),
    .nRAMUWE  (nRAMUWE),
    .nOE      (nOE),
    .RAMReady (RAMReady)
  );

  always #5 FCLK = ~FCLK;

  task automatic chk(input string tag, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [7:0] exp);
    @(posedge FCLK);
    #1;
    chk(tag, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RES = 1'b1; BACT = 1'b0; RAMCS = 1'b0; nWE = 1'b1;
    nLDS = 1'b1; nUDS = 1'b1; RefReq = 1'b0; RefUrg = 1'b0;
    repeat (2) @(posedge FCLK);
    #1 chk("reset", IDL);
    RES = 1'b0;
    repeat (3) @(posedge FCLK);
    #1 chk("idle", IDL);

    // read, defaults
    BACT = 1'b1; RAMCS = 1'b1; nWE = 1'b1;
    step("rd_ras", RASV);
    step("rd_cas0", CRD);
    step("rd_cas1", CRD);
    step("rd_rdy", HRD);
    step("rd_hold5", HRD);
    step("rd_hold6", HRD);
    BACT = 1'b0;
    step("rd_pre7", IDL);
    step("rd_pre8", IDL);
    step("rd_idle9", IDL);

    // write, lower byte only
    BACT = 1'b1; nWE = 1'b0; nLDS = 1'b0; nUDS = 1'b1;
    step("wr_ras", RASV);
    step("wr_cas0", CWL);
    step("wr_cas1", CWL);
    step("wr_rdy", HWL);
    BACT = 1'b0;
    step("wr_pre0", IDL);
    nWE = 1'b1; nLDS = 1'b1; nUDS = 1'b1;
    step("wr_pre1", IDL);
    step("wr_idle", IDL);

    // lone refresh, then a request landing in precharge
    RefReq = 1'b1;
    step("ref_ack", RCAS);
    RefReq = 1'b0;
    step("ref_ras0", RRAS);
    step("ref_ras1", RRAS);
    step("ref_ras2", RRAS);
    step("ref_pre0", IDL);
    BACT = 1'b1; RAMCS = 1'b1;
    step("ref_pre1", IDL);
    step("ref_idle", IDL);
    step("pre_nras", RASV);
    step("pre_cas0", CRD);
    step("pre_cas1", CRD);
    step("pre_rdy", HRD);
    BACT = 1'b0;
    step("pre_end0", IDL);
    step("pre_end1", IDL);
    step("pre_idle", IDL);

    // refresh and access together: access first
    BACT = 1'b1; RefReq = 1'b1;
    step("both_ras", RASV);
    step("both_cas0", CRD);
    step("both_cas1", CRD);
    step("both_rdy", HRD);
    BACT = 1'b0;
    step("both_pre0", IDL);
    step("both_pre1", IDL);
    step("both_idle", IDL);
    step("both_ack", RCAS);
    RefReq = 1'b0;
    step("both_ras0", RRAS);
    step("both_ras1", RRAS);
    step("both_ras2", RRAS);
    step("both_p0", IDL);
    step("both_p1", IDL);
    step("both_i", IDL);

    // urgent refresh raised during CAS
    BACT = 1'b1;
    step("urg_ras", RASV);
    step("urg_cas0", CRD);
    RefUrg = 1'b1;
    step("urg_cas1", CRD);
    RefUrg = 1'b0;
    step("urg_rdy", HRD);
    BACT = 1'b0;
    step("urg_pre0", IDL);
    BACT = 1'b1;
    step("urg_pre1", IDL);
    step("urg_ack", RCAS);
    step("urg_r0", RRAS);
    step("urg_r1", RRAS);
    step("urg_r2", RRAS);
    step("urg_p0", IDL);
    step("urg_p1", IDL);
    step("urg_idle", IDL);
    step("urg_nras", RASV);
    step("urg_c0", CRD);
    step("urg_c1", CRD);
    step("urg_rdy2", HRD);
    BACT = 1'b0;
    step("urg_e0", IDL);
    step("urg_e1", IDL);
    step("urg_e2", IDL);

    // BACT dropped in RAS: CAS finishes, no RAMReady
    BACT = 1'b1;
    step("ab_ras", RASV);
    BACT = 1'b0;
    step("ab_cas0", CRD);
    step("ab_cas1", CRD);
    step("ab_pre0", IDL);
    step("ab_pre1", IDL);
    step("ab_idle", IDL);

    // reset during HOLD
    BACT = 1'b1;
    step("rs_ras", RASV);
    step("rs_cas0", CRD);
    step("rs_cas1", CRD);
    step("rs_rdy", HRD);
    #2 RES = 1'b1;
    #1 chk("rs_async", IDL);
    BACT = 1'b0;
    #2 RES = 1'b0;
    step("rs_after0", IDL);
    step("rs_after1", IDL);

    // four refresh pulses during a long HOLD
    BACT = 1'b1;
    step("q_ras", RASV);
    step("q_cas0", CRD);
    step("q_cas1", CRD);
    step("q_rdy", HRD);
    for (int i = 0; i < 4; i++) begin
      RefReq = 1'b1;
      step("q_hold_hi", HRD);
      RefReq = 1'b0;
      step("q_hold_lo", HRD);
    end
    BACT = 1'b0;
    acks = 0;
    repeat (40) begin
      @(posedge FCLK);
      #1;
      if (RefAck) acks++;
    end
    n_chk++;
    assert (acks === EXP_ACKS) else begin
      n_fail++;
      $error("FAIL q_acks: observed %0d expected %0d", acks, EXP_ACKS);
    end
    chk("q_end", IDL);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
